// File: rtl/demodulador_pwm.sv
`default_nettype none
// ============================================================================
// Module      : demodulador_pwm
// Description : Recovers a FRAME_BITS-wide sample stream from a single-bit PWM
//               line. The line is synchronized, its high time is integrated
//               over a free-running frame of 2^FRAME_BITS cycles, and the
//               count is mapped back to the sample value. Samples are offered
//               downstream through a valid/ready handshake.
//
// Ports       : clk         - system clock, rising edge
//               reset_n     - synchronous, active-low reset
//               pwm_in      - PWM line, asynchronous to clk
//               dato        - last recovered sample
//               dato_valid  - dato holds an unconsumed sample
//               dato_ready  - consumer accepts dato when valid & ready
//               activo      - last completed frame saw a rising edge
//               overrun     - sticky: an unconsumed sample was overwritten
//
// Revision    : 1.0 - initial release
// ============================================================================
module demodulador_pwm #(
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pwm_in,
    output logic [FRAME_BITS-1:0] dato,
    output logic                  dato_valid,
    input  logic                  dato_ready,
    output logic                  activo,
    output logic                  overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [FRAME_BITS-1:0] c_FC_MAX  = {FRAME_BITS{1'b1}};
    localparam logic [FRAME_BITS-1:0] c_ONE     = {{(FRAME_BITS-1){1'b0}}, 1'b1};
    localparam logic [FRAME_BITS-1:0] c_ZERO    = {FRAME_BITS{1'b0}};
    localparam logic [FRAME_BITS:0]   c_HC_ZERO = {(FRAME_BITS+1){1'b0}};

    // State encoding
    localparam logic [0:0] c_ST_DESCARTE = 1'b0;  // first frame after reset is dropped
    localparam logic [0:0] c_ST_MIDIENDO = 1'b1;  // normal measurement

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                  r_sync_meta;
    logic                  r_pwm_s;
    logic                  r_pwm_p;
    logic [FRAME_BITS-1:0] r_fc;
    logic [FRAME_BITS:0]   r_hc;
    logic                  r_ef;
    logic [0:0]            r_state;
    logic [FRAME_BITS-1:0] r_dato;
    logic                  r_dato_valid;
    logic                  r_activo;
    logic                  r_overrun;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_fin;
    logic                  w_rise;
    logic [FRAME_BITS:0]   w_total;
    logic [FRAME_BITS-1:0] w_sample;
    logic [0:0]            w_state_nxt;
    logic                  w_load;
    logic                  w_accept;

    assign w_fin    = (r_fc == c_FC_MAX);
    assign w_rise   = r_pwm_s & ~r_pwm_p;
    assign w_accept = r_dato_valid & dato_ready;

    // The last cycle of the frame is added here rather than in r_hc so the
    // counter can be cleared on the same edge without losing that cycle.
    assign w_total  = r_hc + {{FRAME_BITS{1'b0}}, r_pwm_s};

    // A sample s produces s+1 high cycles, so subtract one. A full frame of
    // highs (top bit set, low bits zero) maps to all ones; an all-low frame
    // stays at zero instead of wrapping.
    always_comb begin
        w_sample = c_ZERO;
        if (w_total[FRAME_BITS]) begin
            w_sample = c_FC_MAX;
        end else if (w_total[FRAME_BITS-1:0] != c_ZERO) begin
            w_sample = w_total[FRAME_BITS-1:0] - c_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Input synchronizer and edge history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b0;
            r_pwm_s     <= 1'b0;
            r_pwm_p     <= 1'b0;
        end else begin
            r_sync_meta <= pwm_in;
            r_pwm_s     <= r_sync_meta;
            r_pwm_p     <= r_pwm_s;
        end
    end

    // ------------------------------------------------------------------------
    // Frame counter, high counter and edge flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fc <= c_ZERO;
            r_hc <= c_HC_ZERO;
            r_ef <= 1'b0;
        end else begin
            r_fc <= r_fc + c_ONE;
            if (w_fin) begin
                r_hc <= c_HC_ZERO;
                r_ef <= 1'b0;
            end else begin
                r_hc <= w_total;
                r_ef <= r_ef | w_rise;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_DESCARTE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_DESCARTE: begin
                // Synchronizer was still filling during this frame.
                if (w_fin) begin
                    w_state_nxt = c_ST_MIDIENDO;
                end
            end
            c_ST_MIDIENDO: begin
                if (w_fin) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_DESCARTE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output registers and handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dato       <= c_ZERO;
            r_dato_valid <= 1'b0;
            r_activo     <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                // A new sample wins over a same-edge accept: valid stays
                // high and nothing was lost, so overrun only when the old
                // sample was not being taken.
                r_dato       <= w_sample;
                r_activo     <= r_ef | w_rise;
                r_dato_valid <= 1'b1;
                if (r_dato_valid && !dato_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_dato_valid <= 1'b0;
            end
        end
    end

    assign dato       = r_dato;
    assign dato_valid = r_dato_valid;
    assign activo     = r_activo;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_demodulador_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_demodulador_pwm
// Description : Self-checking bench for demodulador_pwm. A windowed-sum model
//               of the PWM history predicts every output each cycle; directed
//               scenarios add literal expectations for the key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demodulador_pwm;

    localparam int FB    = 8;
    localparam int FRAME = 256;
    localparam int HIST  = 300;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          pwm_in     = 1'b0;
    logic          dato_ready = 1'b1;
    logic [FB-1:0] dato;
    logic          dato_valid;
    logic          activo;
    logic          overrun;

    demodulador_pwm #(.FRAME_BITS(FB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .dato       (dato),
        .dato_valid (dato_valid),
        .dato_ready (dato_ready),
        .activo     (activo),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // PWM source: sawtooth compare, saw <= sample drives 1
    // ------------------------------------------------------------------------
    int gen_mode   = 0;   // 0 const low, 1 const high, 2 sawtooth compare
    int gen_sample = 0;
    int gen_phase  = 0;
    int saw_cnt    = 0;

    always @(negedge clk) begin
        saw_cnt = saw_cnt + 1;
        case (gen_mode)
            0:       pwm_in = 1'b0;
            1:       pwm_in = 1'b1;
            default: pwm_in = (((saw_cnt + gen_phase) % FRAME) <= gen_sample);
        endcase
    end

    // ------------------------------------------------------------------------
    // Model: each frame result is the high count of the synchronized line
    // over the 256-cycle window ending at the frame edge.
    // ------------------------------------------------------------------------
    int      m_e = 0;          // edges since reset release
    logic    m_hist[$];        // m_hist[HIST-1] = pwm_in sampled at edge m_e
    logic [FB-1:0] m_dato   = '0;
    logic    m_valid   = 1'b0;
    logic    m_activo  = 1'b0;
    logic    m_overrun = 1'b0;
    int      m_total;
    logic    m_edge;

    function automatic logic in_ago(input int k);
        return m_hist[HIST-1-k];
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_e = 0;
            m_hist.delete();
            for (int i = 0; i < HIST; i++) m_hist.push_back(1'b0);
            m_dato    = '0;
            m_valid   = 1'b0;
            m_activo  = 1'b0;
            m_overrun = 1'b0;
        end else begin
            m_e = m_e + 1;
            m_hist.push_back(pwm_in);
            void'(m_hist.pop_front());
            if ((m_e % FRAME == 0) && (m_e > FRAME)) begin
                m_total = 0;
                m_edge  = 1'b0;
                for (int k = 2; k <= FRAME + 1; k++) begin
                    if (in_ago(k)) m_total = m_total + 1;
                    if (in_ago(k) && !in_ago(k + 1)) m_edge = 1'b1;
                end
                if (m_valid && !dato_ready) m_overrun = 1'b1;
                m_dato   = (m_total == 0) ? '0 : FB'(m_total - 1);
                m_activo = m_edge;
                m_valid  = 1'b1;
            end else if (m_valid && dato_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare
    // ------------------------------------------------------------------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_dato",       int'(dato),       int'(m_dato));
            chk("cmp_dato_valid", int'(dato_valid), int'(m_valid));
            chk("cmp_activo",     int'(activo),     int'(m_activo));
            chk("cmp_overrun",    int'(overrun),    int'(m_overrun));
        end
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dato_valid && n < 700);
        if (!dato_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    // Switch the source, drop the mixed frame, then check a clean one.
    task automatic pattern(input string name, input int mode, input int sample,
                           input int phase, input int exp_dato, input int exp_act);
        int n;
        gen_mode   = mode;
        gen_sample = sample;
        gen_phase  = phase;
        wait_valid(n);
        wait_valid(n);
        chk({name, "_dato"},   int'(dato),   exp_dato);
        chk({name, "_activo"}, int'(activo), exp_act);
    endtask

    initial begin
        int n;
        int guard;

        // Reset from power-up
        reset_n = 1'b0;
        tick(3);
        chk_en = 1'b1;
        chk("reset_dato",    int'(dato),       0);
        chk("reset_valid",   int'(dato_valid), 0);
        chk("reset_activo",  int'(activo),     0);
        chk("reset_overrun", int'(overrun),    0);
        reset_n = 1'b1;

        // Constant low: first sample after edge 512, then every 256
        wait_valid(n);
        chk("first_valid_edge", n, 512);
        chk("low_dato",   int'(dato),   0);
        chk("low_activo", int'(activo), 0);
        wait_valid(n);
        chk("valid_period", n, 256);
        chk("low_overrun", int'(overrun), 0);

        // Constant high
        pattern("high", 1, 0, 0, 255, 0);

        // Mid-scale at several phases
        pattern("mid_ph0",   2, 127, 0,   127, 1);
        pattern("mid_ph37",  2, 127, 37,  127, 1);
        pattern("mid_ph200", 2, 127, 200, 127, 1);

        // Low and high ends
        pattern("s0",   2, 0,   11, 0,   1);
        pattern("s254", 2, 254, 90, 254, 1);

        // Ready asserted exactly on an end-of-frame edge
        gen_sample = 127;
        wait_valid(n);
        wait_valid(n);
        dato_ready = 1'b0;
        tick(255);
        dato_ready = 1'b1;
        tick(1);
        chk("simul_valid",   int'(dato_valid), 1);
        chk("simul_dato",    int'(dato),       127);
        chk("simul_overrun", int'(overrun),    0);
        tick(1);
        chk("simul_drained", int'(dato_valid), 0);

        // Overrun: hold ready low for two frames while the sample changes
        wait_valid(n);
        dato_ready = 1'b0;
        gen_sample = 50;
        tick(256);
        chk("ovr_valid1",   int'(dato_valid), 1);
        chk("ovr_overrun1", int'(overrun),    1);
        tick(256);
        chk("ovr_valid2",   int'(dato_valid), 1);
        chk("ovr_dato2",    int'(dato),       50);
        chk("ovr_overrun2", int'(overrun),    1);
        dato_ready = 1'b1;
        tick(1);
        chk("ovr_drained", int'(dato_valid), 0);
        chk("ovr_sticky",  int'(overrun),    1);

        // Reset for one cycle at fc = 100
        guard = 0;
        while ((m_e % FRAME) != 100 && guard < 600) begin
            tick(1);
            guard++;
        end
        chk("fc100_reached", int'((m_e % FRAME) == 100), 1);
        reset_n = 1'b0;
        tick(1);
        chk("midrst_dato",    int'(dato),       0);
        chk("midrst_valid",   int'(dato_valid), 0);
        chk("midrst_activo",  int'(activo),     0);
        chk("midrst_overrun", int'(overrun),    0);
        reset_n = 1'b1;
        wait_valid(n);
        chk("midrst_first_valid_edge", n, 512);
        chk("midrst_dato_after", int'(dato), 50);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/demodulador_pwm.md
# demodulador_pwm

PWM demodulator that recovers an 8-bit sample stream from a single-bit PWM line. The PWM source compares an 8-bit free-running sawtooth against the sample and drives 1 when `saw <= sample`. This block sits at the receiving end of that line, for example on a JB input pin. It measures the high time of the line over each frame, converts it back to the sample value, and hands the sample to downstream logic through a valid/ready handshake.

## Interface
- `FRAME_BITS`, default 8: the frame length is 2^FRAME_BITS clock cycles; this must equal the sawtooth period. The sample width is FRAME_BITS.
- `clk` in 1: system clock; all logic updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `pwm_in` in 1: PWM line, asynchronous to `clk`.
- `dato` out FRAME_BITS: last recovered sample.
- `dato_valid` out 1: `dato` holds an unconsumed sample.
- `dato_ready` in 1: consumer accepts `dato` on any edge where `dato_valid` and `dato_ready` are both 1.
- `activo` out 1: the last completed frame contained at least one rising edge on the synchronized PWM signal.
- `overrun` out 1: sticky flag; a completed sample overwrote a sample that had not been consumed.

## Operation
- **Input synchronizer**
  - `pwm_in` passes through a 2-flop synchronizer to give `pwm_s`.
  - `pwm_p` is `pwm_s` delayed by one cycle.
  - A rising edge is `pwm_s & ~pwm_p`.
- **Frame counter `fc`**
  - FRAME_BITS wide, free-running 0..2^FRAME_BITS-1, wraps to 0.
  - The frame is not phase-aligned to the sawtooth. Any window of 2^FRAME_BITS cycles of a periodic PWM contains the same high count, so alignment is not needed.
- **High counter `hc`**
  - FRAME_BITS+1 bits wide, range 0..256.
  - Adds `pwm_s` every cycle.
- **Edge flag `ef`**
  - Set on any rising edge.
- **End of frame (`fc` = max)**
  - `total = hc + pwm_s`.
  - `hc` and `ef` clear; this frame's final-cycle edge is folded into the result.
- **Conversion**
  - `dato = (total == 0) ? 0 : total - 1`.
  - This inverts the `saw <= sample` rule: sample s gives s+1 high cycles, and a constant-high line gives 255.
- **State machine**
  - DESCARTE: the first frame after reset is discarded because the synchronizer is still filling. At end of frame, go to MIDIENDO; `dato`, `dato_valid` and `activo` do not change.
  - MIDIENDO: at every end of frame, load `dato`, set `activo` to the frame's edge flag (including an edge on the last cycle), and set `dato_valid` to 1.
- **Handshake**
  - `dato_valid` falls on an edge where it is accepted (`dato_valid & dato_ready`), unless a frame completes on the same edge; then it stays 1 with the new `dato` and no overrun is flagged.
  - If a frame completes while `dato_valid` = 1 and `dato_ready` = 0, set `overrun` = 1 and overwrite `dato`. `overrun` clears only on reset.
  - `dato` is stable while `dato_valid` = 1, except when it is overwritten as above.

## Timing
- **Reset**
  - `dato` = 0, `dato_valid` = 0, `activo` = 0, `overrun` = 0.
  - `fc`, `hc`, `ef`, the synchronizer flops and `pwm_p` = 0; state = DESCARTE.
- **Reset mid-frame**
  - Behaves identically to reset from power-up; the partial frame is lost and the next frame is discarded.
- **Latency**
  - `pwm_in` reaches `pwm_s` 2 edges later.
  - A sample is produced at the edge where `fc` = max; `dato_valid` is high immediately after that edge.
- **First sample**
  - `dato_valid` first rises after the 512th rising edge with `reset_n` = 1 (for FRAME_BITS = 8).
  - It then rises every 256 edges.
- **Counter bound**
  - `hc` never exceeds 255 before the add, so `total` fits in FRAME_BITS+1 bits without overflow.

## Test plan
- **Constant low:** `pwm_in` = 0 from reset. The first `dato_valid` appears after edge 512 with `dato` = 0 and `activo` = 0; it repeats every 256 cycles; `overrun` = 0 with `dato_ready` = 1.
- **Constant high:** `pwm_in` = 1. `dato` = 255, `activo` = 0.
- **Mid-scale PWM:** a bench sawtooth-compare model drives sample 127 at an arbitrary phase offset (tested at 0, 37 and 200). Every valid frame gives `dato` = 127 and `activo` = 1.
- **Low end:**
  - Sample 0 (one high cycle per period) gives `dato` = 0, `activo` = 1.
  - Sample 254 gives `dato` = 254, `activo` = 1.
- **Overrun and simultaneous events:**
  - `dato_ready` = 0 for 2 frames: `dato_valid` stays 1, `dato` shows the newer sample, `overrun` = 1.
  - Pulse `dato_ready` exactly on an end-of-frame edge: `dato_valid` stays 1 with the new sample and `overrun` is unchanged.
- **Reset mid-frame:** assert `reset_n` = 0 for 1 cycle at `fc` = 100. All outputs read 0 the next cycle, and the next valid appears only 512 edges after release.
